// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges in-order writeback (port A) with a FIFO-buffered
// long-latency port B. Optional WAW kill of buffered B results via WB_WAW_KILL_EN.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            a_valid_i,
    input  logic [4:0]      a_rd_i,
    input  logic [XLEN-1:0] a_data_i,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    input  logic [4:0]      b_rd_i,
    input  logic [XLEN-1:0] b_data_i,
    output logic            stall_o,
    output logic            pending_o,
    output logic            reg_write_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rd_din_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      ent_rd_q   [DEPTH];
    logic [4:0]      ent_rd_d   [DEPTH];
    logic [XLEN-1:0] ent_data_q [DEPTH];
    logic [XLEN-1:0] ent_data_d [DEPTH];
`ifdef WB_WAW_KILL_EN
    logic            ent_live_q [DEPTH];
    logic            ent_live_d [DEPTH];
`endif
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_din_q, rd_din_d;

    logic empty, full, push, pop, a_take, head_live;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        // rd==0 results complete the handshake but are never stored
        push      = b_valid_i && !full && (b_rd_i != 5'd0);
        a_take    = !stall_q && a_valid_i && (a_rd_i != 5'd0);
        pop       = !empty && (stall_q || !a_take);
`ifdef WB_WAW_KILL_EN
        head_live = ent_live_q[rd_ptr_q];
`else
        head_live = 1'b1;
`endif

        ent_rd_d    = ent_rd_q;
        ent_data_d  = ent_data_q;
`ifdef WB_WAW_KILL_EN
        ent_live_d  = ent_live_q;
`endif
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        rd_din_d    = rd_din_q;

        if (push) begin
            ent_rd_d[wr_ptr_q]   = b_rd_i;
            ent_data_d[wr_ptr_q] = b_data_i;
`ifdef WB_WAW_KILL_EN
            ent_live_d[wr_ptr_q] = 1'b1;
`endif
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

`ifdef WB_WAW_KILL_EN
        // Applied after the push so a same-cycle entry to the same rd is killed too
        if (a_take) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_rd_d[i] == a_rd_i) ent_live_d[i] = 1'b0;
            end
        end
`endif

        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        if (pop || empty)                     starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
        else                                  starve_d = starve_q;
        stall_d = (starve_d == SW'(STARVE_LIMIT));

        if (a_take) begin
            reg_write_d = 1'b1;
            rd_d        = a_rd_i;
            rd_din_d    = a_data_i;
        end else if (pop && head_live) begin
            reg_write_d = 1'b1;
            rd_d        = ent_rd_q[rd_ptr_q];
            rd_din_d    = ent_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
`ifdef WB_WAW_KILL_EN
                ent_live_q[i] <= 1'b0;
`endif
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            stall_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            rd_din_q    <= '0;
        end else begin
            ent_rd_q    <= ent_rd_d;
            ent_data_q  <= ent_data_d;
`ifdef WB_WAW_KILL_EN
            ent_live_q  <= ent_live_d;
`endif
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            rd_din_q    <= rd_din_d;
        end
    end

    assign b_ready_o   = !full;
    assign pending_o   = !empty;
    assign stall_o     = stall_q;
    assign reg_write_o = reg_write_q;
    assign rd_o        = rd_q;
    assign rd_din_o    = rd_din_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed + random bench for wb_port_arbiter with a queue-based reference model and
// expected-write scoreboard. Build with +define+WB_WAW_KILL_EN to cover the kill feature.
module tb_wb_port_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            a_valid_i;
    logic [4:0]      a_rd_i;
    logic [XLEN-1:0] a_data_i;
    logic            b_valid_i;
    logic            b_ready_o;
    logic [4:0]      b_rd_i;
    logic [XLEN-1:0] b_data_i;
    logic            stall_o;
    logic            pending_o;
    logic            reg_write_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] rd_din_o;

    wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_rd_i(a_rd_i), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_rd_i(b_rd_i), .b_data_i(b_data_i),
        .stall_o(stall_o), .pending_o(pending_o),
        .reg_write_o(reg_write_o), .rd_o(rd_o), .rd_din_o(rd_din_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            live;
    } ent_t;

    ent_t              mq[$];
    logic [5+XLEN-1:0] exp_q[$];
    int                tests = 0;
    int                fails = 0;
    int                m_starve;
    bit                m_stall;
    logic [4:0]        m_rd;
    logic [XLEN-1:0]   m_din;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_rd     = '0;
        m_din    = '0;
    endtask

    task automatic set_idle();
        a_valid_i = 1'b0; a_rd_i = '0; a_data_i = '0;
        b_valid_i = 1'b0; b_rd_i = '0; b_data_i = '0;
    endtask

    task automatic set_a(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
        a_valid_i = v; a_rd_i = rd; a_data_i = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
        b_valid_i = v; b_rd_i = rd; b_data_i = d;
    endtask

    // One clock: check pre-edge outputs, predict this cycle's selection, advance, score the write
    task automatic step();
        int                sz;
        bit                full, popped, sel_a, exp_wr;
        ent_t              h, e;
        logic [5+XLEN-1:0] got_w, exp_w;
        sz   = mq.size();
        full = (sz == DEPTH);
        check("b_ready", b_ready_o, !full);
        check("pending", pending_o, sz != 0);
        check("stall", stall_o, m_stall);
        exp_wr = 0; popped = 0; sel_a = 0;
        h = '0;
        if (m_stall) begin
            if (sz > 0) begin h = mq.pop_front(); popped = 1; end
        end else if (a_valid_i && a_rd_i != 0) begin
            sel_a = 1;
        end else if (sz > 0) begin
            h = mq.pop_front(); popped = 1;
        end
        if (sel_a) begin
            exp_wr = 1;
            exp_q.push_back({a_rd_i, a_data_i});
`ifdef WB_WAW_KILL_EN
            foreach (mq[i]) if (mq[i].rd == a_rd_i) mq[i].live = 1'b0;
`endif
        end else if (popped && h.live) begin
            exp_wr = 1;
            exp_q.push_back({h.rd, h.data});
        end
        if (b_valid_i && !full && b_rd_i != 0) begin
            e.rd = b_rd_i; e.data = b_data_i; e.live = 1'b1;
`ifdef WB_WAW_KILL_EN
            if (sel_a && b_rd_i == a_rd_i) e.live = 1'b0;
`endif
            mq.push_back(e);
        end
        if (popped || sz == 0) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        m_stall = (m_starve == LIMIT);

        @(posedge clk_i); #1;
        check("reg_write", reg_write_o, exp_wr);
        got_w = {rd_o, rd_din_o};
        if (exp_wr) begin
            exp_w = exp_q.pop_front();
            check("write_data", got_w, exp_w);
            m_rd = exp_w[5+XLEN-1:XLEN]; m_din = exp_w[XLEN-1:0];
        end else begin
            check("hold", got_w, {m_rd, m_din});
        end
    endtask

    int stall_first;
    int stall_count;

    initial begin
        set_idle();
        model_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_reg_write", reg_write_o, 0);
        check("rst_rd", rd_o, 0);
        check("rst_din", rd_din_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_pending", pending_o, 0);
        check("rst_b_ready", b_ready_o, 1);
        rst_i = 1'b0;

        // Port A single write
        set_a(1, 5'd5, 32'hDEADBEEF); step(); set_idle();
        check("a_lat_rd", rd_o, 5);
        check("a_lat_din", rd_din_o, 32'hDEADBEEF);
        step();

        // Port B single push: two-cycle latency
        set_b(1, 5'd7, 32'h11); step(); set_idle();
        check("b_not_bypassed", reg_write_o, 0);
        step();
        check("b_lat_rd", rd_o, 7);
        step();

        // rd==0 push discarded
        set_b(1, 5'd0, 32'h55); step(); set_idle();
        check("b_rd0_pending", pending_o, 0);
        repeat (2) step();

        // Fill with A busy, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1, 5'(10 + i), $urandom());
            set_b(1, 5'(20 + i), $urandom());
            step();
        end
        check("fill_b_ready", b_ready_o, 0);
        set_a(1, 5'd15, $urandom()); set_b(1, 5'd30, $urandom()); step();
        set_a(0, 5'd0, '0); set_b(1, 5'd31, $urandom()); step();
        set_idle();
        repeat (6) step();

        // Starvation: one entry, A valid every cycle
        stall_first = -1; stall_count = 0;
        for (int i = 0; i < 12; i++) begin
            set_a(1, 5'($urandom_range(1, 11)), $urandom());
            if (i == 0) set_b(1, 5'd12, 32'hCAFE); else set_b(0, 5'd0, '0);
            step();
            if (stall_o) begin
                if (stall_first < 0) stall_first = i + 1;
                stall_count++;
            end
        end
        check("starve_cycle", stall_first, 9);
        check("starve_len", stall_count, 1);
        set_idle();
        repeat (2) step();

        // A with rd==0 gives the slot to the FIFO head
        set_a(1, 5'd1, 32'h1); set_b(1, 5'd3, 32'h33); step();
        set_a(1, 5'd0, 32'hBAD); set_b(0, 5'd0, '0); step();
        check("a_rd0_slot", rd_o, 3);
        set_idle(); step();

        // WAW: buffered rd=9 followed by an A write to rd=9
        set_a(1, 5'd1, 32'h2); set_b(1, 5'd9, 32'h99); step();
        set_a(1, 5'd9, 32'hA9); set_b(0, 5'd0, '0); step();
        set_idle(); step();
`ifdef WB_WAW_KILL_EN
        check("waw_dead_pop", reg_write_o, 0);
`else
        check("waw_second_write", reg_write_o, 1);
`endif
        // Same-cycle push and A write to one rd
        set_a(1, 5'd14, 32'hE1); set_b(1, 5'd14, 32'hE2); step();
        set_idle(); repeat (2) step();

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            set_a($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom());
            set_b($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom());
            step();
        end
        set_idle();
        repeat (8) step();

        // Asynchronous reset mid-stream with a write on the outputs
        set_a(1, 5'd2, 32'h20); set_b(1, 5'd4, 32'h40); step();
        set_a(1, 5'd6, 32'h60); set_b(1, 5'd8, 32'h80); step();
        set_idle();
        #2 rst_i = 1'b1;
        #1;
        check("arst_reg_write", reg_write_o, 0);
        check("arst_rd", rd_o, 0);
        check("arst_din", rd_din_o, 0);
        check("arst_stall", stall_o, 0);
        check("arst_pending", pending_o, 0);
        check("arst_b_ready", b_ready_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_reset();
        repeat (4) step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
